// File: rtl/gbus_sram_responder.sv
// Single-port word SRAM responder on the gbus: fixed-latency read/write with range check.
// Define GBUS_RESP_COUNTERS_EN to add the rd_count/wr_count completion counters.
module gbus_sram_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_err
`ifdef GBUS_RESP_COUNTERS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + SPAN;
  localparam logic [31:0] ERR_DATA = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               wr_q, wr_d;
  logic               oor_q, oor_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               req_oor;
  logic [IDX_W-1:0]   req_idx;
  logic               commit;

  // Range test in 33 bits so BASE_ADDR + span never wraps.
  always_comb begin
    req_oor = ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= END_ADDR);
    req_idx = IDX_W'((addr - BASE_ADDR) >> 2);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    oor_d    = oor_q;
    busy     = 1'b1;
    rdata    = 32'h0;
    addr_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (ren || wen) begin
          idx_d   = req_idx;
          wdata_d = wdata;
          be_d    = byte_en;
          wr_d    = wen;
          oor_d   = req_oor;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leaving when the count hits zero puts RESP exactly LATENCY cycles after acceptance.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        busy     = 1'b0;
        addr_err = oor_q;
        if (!wr_q) begin
          rdata = oor_q ? ERR_DATA : mem[idx_q];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    wr_q    <= wr_d;
    oor_q   <= oor_d;
  end

  // Reset forces IDLE asynchronously, so an interrupted write never reaches this edge.
  assign commit = (state_q == RESP) && wr_q && !oor_q;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && be_q[i]) begin
        mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef GBUS_RESP_COUNTERS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else if (state_q == RESP && !oor_q) begin
      if (wr_q) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_gbus_sram_responder.sv
// Randomized bench for gbus_sram_responder against a word-array reference model.
module tb_gbus_sram_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  byte_en;
  logic        ren, wen, busy, addr_err;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1;
  logic        ren1, wen1, busy1, err1;
`ifdef GBUS_RESP_COUNTERS_EN
  logic [31:0] rd_count, wr_count, rd_count1, wr_count1;
`endif

  gbus_sram_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .ren(ren), .wen(wen), .rdata(rdata), .busy(busy), .addr_err(addr_err)
`ifdef GBUS_RESP_COUNTERS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  gbus_sram_responder #(.LATENCY(1), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut1 (
    .CLK(CLK), .nRST(nRST), .addr(addr1), .wdata(wdata1), .byte_en(be1),
    .ren(ren1), .wen(wen1), .rdata(rdata1), .busy(busy1), .addr_err(err1)
`ifdef GBUS_RESP_COUNTERS_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_m [int];
  int unsigned rd_exp = 0;
  int unsigned wr_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned la = {32'h0, a};
    longint unsigned lb = {32'h0, BASE};
    return (la >= lb) && (la < lb + 64'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // In-range addresses come from a preloaded window at both ends of the store.
  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, 19);
      if (k >= 16) k = k + 1004;
      return BASE + 32'(k * 4) + lo;
    end
    case ($urandom_range(0, 3))
      0:       return BASE - 32'($urandom_range(1, 64));
      1:       return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      2:       return lo;
      default: return 32'hFFFF_FFFC + lo;
    endcase
  endfunction

  // Call mid-cycle with the DUT idle; returns mid-cycle with the DUT idle again.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int n;
    bit ok;
    int i;
    logic [31:0] w;
    ok = in_range(a);
    i  = widx(a);
    addr = a; wdata = wd; byte_en = be; wen = wr;
    ren  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge CLK); #1;
    ren = 1'b0; wen = 1'b0; addr = $urandom; wdata = $urandom; byte_en = 4'($urandom);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (busy && n == 1) chk("rdata_wait", rdata, 32'h0);
    end while (busy && n < 20);
    chk("latency", 32'(n), 32'(LAT));
    chk("addr_err", 32'(addr_err), 32'(!ok));
    if (wr) chk("rdata_on_write", rdata, 32'h0);
    else if (!ok) chk("rdata_oor", rdata, 32'hBAD1_BAD1);
    else if (mem_m.exists(i)) chk("rdata", rdata, mem_m[i]);
    if (ok) begin
      if (wr) begin
        w = mem_m.exists(i) ? mem_m[i] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        mem_m[i] = w;
        wr_exp++;
      end else begin
        rd_exp++;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    nRST = 1'b0;
    addr = '0; wdata = '0; byte_en = '0; ren = 1'b0; wen = 1'b0;
    addr1 = '0; wdata1 = '0; be1 = '0; ren1 = 1'b0; wen1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_addr_err", 32'(addr_err), 32'h0);
    chk("reset_busy1", 32'(busy1), 32'h1);
`ifdef GBUS_RESP_COUNTERS_EN
    chk("reset_rd_count", rd_count, 32'h0);
    chk("reset_wr_count", wr_count, 32'h0);
`endif
    nRST = 1'b1;
    @(negedge CLK);

    for (int k = 0; k < 20; k++) begin
      txn(1'b1, BASE + 32'((k < 16 ? k : k + 1004) * 4), $urandom, 4'hF);
    end

    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    chk("full_word_read", mem_m[4], 32'hDEAD_BEEF);
    txn(1'b1, 32'h8000_0010, 32'h0000_00AA, 4'b0001);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    txn(1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF);
    txn(1'b0, 32'h8000_0FFC, 32'h0, 4'h0);
    txn(1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'b0000);
    txn(1'b0, 32'h8000_0014, 32'h0, 4'h0);

    // LATENCY=1 responder: one write, then ren held for four cycles.
    addr1 = BASE; wdata1 = 32'h1234_5678; be1 = 4'hF; wen1 = 1'b1;
    @(negedge CLK);
    wen1 = 1'b0;
    chk("l1_write_busy", 32'(busy1), 32'h0);
    @(negedge CLK);
    ren1 = 1'b1;
    #1;
    chk("l1_cycle0_busy", 32'(busy1), 32'h1);
    for (int c = 1; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("l1_cycle%0d_busy", c), 32'(busy1), (c % 2 == 1) ? 32'h0 : 32'h1);
      if (c % 2 == 1) chk("l1_rdata", rdata1, 32'h1234_5678);
      else            chk("l1_rdata_idle", rdata1, 32'h0);
    end
    ren1 = 1'b0;
    @(negedge CLK);

    // Reset during WAIT must drop the pending write.
    old_w = mem_m[8];
    addr = BASE + 32'd32; wdata = ~old_w; byte_en = 4'hF; wen = 1'b1;
    @(posedge CLK); #1;
    wen = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("rst_wait_busy", 32'(busy), 32'h1);
    chk("rst_wait_rdata", rdata, 32'h0);
    chk("rst_wait_err", 32'(addr_err), 32'h0);
    @(negedge CLK);
    chk("rst_hold_busy", 32'(busy), 32'h1);
    nRST = 1'b1;
    rd_exp = 0; wr_exp = 0;
    @(negedge CLK);
    chk("post_reset_busy", 32'(busy), 32'h1);
    txn(1'b0, BASE + 32'd32, 32'h0, 4'h0);
    chk("rst_old_value_kept", mem_m[8], old_w);

    txn(1'b0, BASE + 32'd4,  32'h0, 4'h0);
    txn(1'b0, BASE + 32'd8,  32'h0, 4'h0);
    txn(1'b1, BASE + 32'd12, $urandom, 4'hF);
    txn(1'b1, BASE + 32'd0,  $urandom, 4'b1010);
    txn(1'b1, 32'h7000_0000, $urandom, 4'hF);
`ifdef GBUS_RESP_COUNTERS_EN
    chk("rd_count_directed", rd_count, 32'd3);
    chk("wr_count_directed", wr_count, 32'd2);
`endif

    for (int t = 0; t < 120; t++) begin
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
    end
`ifdef GBUS_RESP_COUNTERS_EN
    chk("rd_count_final", rd_count, 32'(rd_exp));
    chk("wr_count_final", wr_count, 32'(wr_exp));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
